// File: rtl/branch_resolve_if.sv
// Bundle for the branch_resolve request/result handshakes and the flush/count sideband.
// Both channels use valid/ready: a transfer happens on the rising edge where valid&ready are 1; once valid is raised the payload holds until that edge.
interface branch_resolve_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  cond;
    logic [15:0] rs_val;
    logic [15:0] pc_plus2;
    logic [15:0] imm;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic        out_taken;
    logic [15:0] out_target;
    logic [7:0]  taken_cnt;

    modport master (
        output in_valid, cond, rs_val, pc_plus2, imm, flush, out_ready,
        input  in_ready, out_valid, out_taken, out_target, taken_cnt
    );

    modport slave (
        input  in_valid, cond, rs_val, pc_plus2, imm, flush, out_ready,
        output in_ready, out_valid, out_taken, out_target, taken_cnt
    );
endinterface

// File: rtl/branch_resolve.sv
// Two-stage branch resolver: S1 captures the request, S2 holds the resolved taken/target.
// Also keeps a saturating count of taken branches actually delivered to the consumer.
module branch_resolve (
    input  logic            clk,
    input  logic            rst,
    branch_resolve_if.slave bus
);
    logic        s1_valid;
    logic [1:0]  s1_cond;
    logic [15:0] s1_rs;
    logic [15:0] s1_pc;
    logic [15:0] s1_imm;
    logic        s2_valid;
    logic        s2_taken;
    logic [15:0] s2_target;
    logic [7:0]  cnt;

    logic        s1_adv;
    logic        accept;
    logic        deliver;
    logic        zero;
    logic        sign;
    logic        taken_c;
    logic [15:0] target_c;

    // in_ready depends only on state, flush and out_ready so it never loops back through in_valid.
    assign s1_adv       = s1_valid & (~s2_valid | bus.out_ready);
    assign bus.in_ready = ~bus.flush & (~s1_valid | s1_adv);
    assign accept       = bus.in_valid & bus.in_ready;
    assign deliver      = s2_valid & bus.out_ready;

    always_comb begin
        zero     = (s1_rs == 16'h0000);
        sign     = s1_rs[15];
        taken_c  = 1'b0;
        unique case (s1_cond)
            2'b00: taken_c = zero;
            2'b01: taken_c = ~zero;
            2'b10: taken_c = sign;
            2'b11: taken_c = ~sign;
        endcase
        // 16-bit sum drops the carry, so targets wrap around the address space.
        target_c = taken_c ? (s1_pc + s1_imm) : s1_pc;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid  <= 1'b0;
            s1_cond   <= 2'b00;
            s1_rs     <= 16'h0000;
            s1_pc     <= 16'h0000;
            s1_imm    <= 16'h0000;
            s2_valid  <= 1'b0;
            s2_taken  <= 1'b0;
            s2_target <= 16'h0000;
            cnt       <= 8'h00;
        end else if (bus.flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (deliver && s2_taken && (cnt != 8'hFF))
                cnt <= cnt + 8'd1;

            if (s1_adv) begin
                s2_valid  <= 1'b1;
                s2_taken  <= taken_c;
                s2_target <= target_c;
            end else if (deliver) begin
                s2_valid <= 1'b0;
            end

            if (accept) begin
                s1_valid <= 1'b1;
                s1_cond  <= bus.cond;
                s1_rs    <= bus.rs_val;
                s1_pc    <= bus.pc_plus2;
                s1_imm   <= bus.imm;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // Result fields read as zero whenever no result is being presented.
    assign bus.out_valid  = s2_valid;
    assign bus.out_taken  = s2_valid & s2_taken;
    assign bus.out_target = s2_valid ? s2_target : 16'h0000;
    assign bus.taken_cnt  = cnt;
endmodule

// File: tb/tb_branch_resolve.sv
// Bench for branch_resolve: directed scenarios plus random traffic, checked by a queue-based scoreboard.
module tb_branch_resolve;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  branch_resolve_if bif();
  branch_resolve dut (.clk(clk), .rst(rst), .bus(bif));

  int checks = 0;
  int failures = 0;
  logic [16:0] exp_q[$];
  int model_cnt = 0;
  bit hold = 0;
  logic [16:0] hold_data = '0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference: decide taken from the condition rules, then pick target with 16-bit wrap.
  function automatic logic [16:0] ref_resolve(logic [1:0] c, logic [15:0] r, logic [15:0] p, logic [15:0] i);
    logic t;
    case (c)
      2'd0:    t = (r == 16'd0);
      2'd1:    t = (r != 16'd0);
      2'd2:    t = ($signed(r) < 0);
      default: t = ($signed(r) >= 0);
    endcase
    return {t, t ? 16'(p + i) : p};
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [16:0] e;
    if (!rst) begin
      exp_q.delete();
      model_cnt = 0;
      hold = 0;
    end else begin
      chk("taken_cnt", 32'(bif.taken_cnt), 32'(model_cnt));
      chk("in_ready", 32'(bif.in_ready), 32'(!bif.flush && (exp_q.size() < 2 || bif.out_ready)));
      if (!bif.out_valid) chk("idle_zero", 32'({bif.out_taken, bif.out_target}), 32'd0);
      if (hold) begin
        chk("hold_valid", 32'(bif.out_valid), 32'd1);
        chk("hold_data", 32'({bif.out_taken, bif.out_target}), 32'(hold_data));
      end
      if (bif.flush) begin
        exp_q.delete();
        hold = 0;
      end else begin
        hold = bif.out_valid && !bif.out_ready;
        hold_data = {bif.out_taken, bif.out_target};
        if (bif.out_valid && bif.out_ready) begin
          if (exp_q.size() == 0) chk("unexpected_out", 32'd1, 32'd0);
          else begin
            e = exp_q.pop_front();
            chk("result", 32'({bif.out_taken, bif.out_target}), 32'(e));
            if (e[16] && model_cnt < 255) model_cnt++;
          end
        end
        if (bif.in_valid && bif.in_ready)
          exp_q.push_back(ref_resolve(bif.cond, bif.rs_val, bif.pc_plus2, bif.imm));
      end
    end
  end

  task automatic do_reset();
    rst = 1'b0;
    bif.in_valid = 1'b0;
    bif.flush = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 32'(bif.out_valid), 32'd0);
    chk("rst_out_taken", 32'(bif.out_taken), 32'd0);
    chk("rst_out_target", 32'(bif.out_target), 32'd0);
    chk("rst_taken_cnt", 32'(bif.taken_cnt), 32'd0);
    chk("rst_in_ready", 32'(bif.in_ready), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [1:0] c, input logic [15:0] r, input logic [15:0] p, input logic [15:0] i);
    bit ok;
    int n;
    n = 0;
    bif.cond = c; bif.rs_val = r; bif.pc_plus2 = p; bif.imm = i;
    bif.in_valid = 1'b1;
    do begin
      @(negedge clk);
      ok = bif.in_ready;
      @(posedge clk); #1;
      n++;
    end while (!ok && n < 200);
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
    bif.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    bit acc;
    bif.in_valid = 0; bif.cond = 0; bif.rs_val = 0; bif.pc_plus2 = 0;
    bif.imm = 0; bif.flush = 0; bif.out_ready = 1;
    do_reset();

    // Single BEQZ with latency check
    bif.cond = 2'b00; bif.rs_val = 16'h0000; bif.pc_plus2 = 16'h0100; bif.imm = 16'h0010;
    bif.in_valid = 1'b1;
    @(posedge clk); #1 bif.in_valid = 1'b0;
    @(negedge clk); chk("lat_early_valid", 32'(bif.out_valid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("lat_valid", 32'(bif.out_valid), 32'd1);
    chk("beqz_taken", 32'(bif.out_taken), 32'd1);
    chk("beqz_target", 32'(bif.out_target), 32'h0110);
    @(posedge clk); #1;
    @(negedge clk); chk("beqz_cnt", 32'(bif.taken_cnt), 32'd1);
    @(posedge clk); #1;

    // Four back-to-back
    do_reset();
    send(2'b01, 16'h0001, 16'h0200, 16'hFFFE);
    send(2'b10, 16'h8000, 16'h0200, 16'hFFFE);
    send(2'b11, 16'h8000, 16'h0200, 16'hFFFE);
    send(2'b00, 16'h0001, 16'h0200, 16'hFFFE);
    wait_idle();
    @(negedge clk); chk("b2b_cnt", 32'(bif.taken_cnt), 32'd2);
    @(posedge clk); #1;

    // Backpressure: two accepted, third waits until release
    bif.out_ready = 1'b0;
    fork
      begin
        send(2'b00, 16'h0000, 16'h1000, 16'h0004);
        send(2'b01, 16'h0000, 16'h2000, 16'h0008);
        send(2'b10, 16'hF000, 16'h3000, 16'h0010);
      end
      begin
        repeat (3) @(negedge clk);
        chk("bp_in_ready", 32'(bif.in_ready), 32'd0);
        chk("bp_out_valid", 32'(bif.out_valid), 32'd1);
        chk("bp_target", 32'(bif.out_target), 32'h1004);
        repeat (3) @(negedge clk);
        @(posedge clk); #1 bif.out_ready = 1'b1;
      end
    join
    wait_idle();

    // Flush with both stages full and a request offered
    do_reset();
    send(2'b00, 16'h0000, 16'h0040, 16'h0002);
    wait_idle();
    bif.out_ready = 1'b0;
    send(2'b01, 16'h0005, 16'h0500, 16'h0010);
    send(2'b01, 16'h0006, 16'h0600, 16'h0010);
    bif.cond = 2'b00; bif.rs_val = 0; bif.pc_plus2 = 16'h0700; bif.imm = 16'h0020;
    bif.in_valid = 1'b1; bif.flush = 1'b1; bif.out_ready = 1'b1;
    @(negedge clk); chk("flush_in_ready", 32'(bif.in_ready), 32'd0);
    @(posedge clk); #1 bif.flush = 1'b0; bif.in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", 32'(bif.out_valid), 32'd0);
    chk("flush_in_ready_after", 32'(bif.in_ready), 32'd1);
    chk("flush_cnt", 32'(bif.taken_cnt), 32'd1);
    repeat (5) @(posedge clk);
    #1;

    // Wrap-around target, then saturation
    send(2'b11, 16'h0000, 16'hFFFE, 16'h0004);
    @(posedge clk); #1;
    @(negedge clk);
    chk("wrap_valid", 32'(bif.out_valid), 32'd1);
    chk("wrap_target", 32'(bif.out_target), 32'h0002);
    @(posedge clk); #1;
    for (int k = 0; k < 260; k++)
      send(2'b00, 16'h0000, 16'($urandom), 16'($urandom));
    wait_idle();
    @(negedge clk); chk("sat_cnt", 32'(bif.taken_cnt), 32'hFF);
    @(posedge clk); #1;

    // Reset mid-operation with both stages full
    bif.out_ready = 1'b0;
    send(2'b01, 16'h0009, 16'h0100, 16'h0100);
    send(2'b01, 16'h000A, 16'h0200, 16'h0100);
    rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_out_valid", 32'(bif.out_valid), 32'd0);
    chk("mid_rst_cnt", 32'(bif.taken_cnt), 32'd0);
    chk("mid_rst_in_ready", 32'(bif.in_ready), 32'd1);
    @(posedge clk); #1;

    // Random traffic with stalls and occasional flush
    for (int k = 0; k < 800; k++) begin
      @(negedge clk);
      acc = (bif.in_valid && bif.in_ready) || bif.flush;
      @(posedge clk); #1;
      bif.out_ready = ($urandom_range(0, 3) != 0);
      bif.flush = ($urandom_range(0, 39) == 0);
      if (!bif.in_valid || acc) begin
        bif.in_valid = ($urandom_range(0, 2) != 0);
        bif.cond = 2'($urandom_range(0, 3));
        case ($urandom_range(0, 3))
          0: bif.rs_val = 16'h0000;
          1: bif.rs_val = 16'h8000 | 16'($urandom);
          default: bif.rs_val = 16'($urandom);
        endcase
        bif.pc_plus2 = 16'($urandom);
        bif.imm = ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'($urandom_range(0, 64));
      end
    end
    bif.in_valid = 1'b0; bif.flush = 1'b0; bif.out_ready = 1'b1;
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
